// File: rtl/ctr_pkg.sv
// Shared definitions for the ctr measurement sequencer: default widths and
// the FSM state encoding.
package ctr_pkg;

  localparam int SIZE_DEF = 32;
  localparam int GW_DEF   = 24;
  localparam int CLR_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ARM     = 3'd2,
    ST_GATE    = 3'd3,
    ST_STOP    = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_HOLD    = 3'd6,
    ST_ABORT   = 3'd7
  } state_t;

endpackage

// File: rtl/ctr_dncnt.sv
// Loadable down-counter. Load wins over decrement; the count sticks at zero
// instead of wrapping. o_tc is high whenever the count is at or below one,
// so a counter that has run out keeps reporting terminal count.
module ctr_dncnt
  import ctr_pkg::*;
#(
  parameter int W = GW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  // count register: load, or saturating decrement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count <= W'(1));

endmodule

// File: rtl/ctr_seq.sv
// Measurement sequencer for the reciprocal counter: clears the counter,
// requests begin, times the gate, requests end, captures cta/ctc and offers
// them on a valid/ready port. A missing acknowledge past tmo cycles aborts
// the run and raises the sticky err flag.
module ctr_seq
  import ctr_pkg::*;
#(
  parameter int size = SIZE_DEF,
  parameter int gw   = GW_DEF,
  parameter int clr  = CLR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [gw-1:0]   gate,
  input  logic [gw-1:0]   tmo,
  output logic            busy,
  output logic            ctr_rst,
  output logic            brq,
  output logic            erq,
  input  logic            bac,
  input  logic            eac,
  input  logic [size-1:0] cta,
  input  logic [size-1:0] ctc,
  output logic [size-1:0] res_cta,
  output logic [size-1:0] res_ctc,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            err
);

  state_t          r_state;
  state_t          w_state_next;
  logic [gw-1:0]   r_gate;
  logic [gw-1:0]   r_tmo;
  logic            r_busy, r_ctr_rst, r_brq, r_erq, r_res_valid, r_err;
  logic [size-1:0] r_res_cta, r_res_ctc;
  logic            w_busy_next, w_ctr_rst_next, w_brq_next, w_erq_next;
  logic            w_res_valid_next, w_err_next;
  logic            w_accept, w_tmo_hit;
  logic            w_sc_load, w_sc_en, w_sc_tc;
  logic [gw-1:0]   w_sc_val;
  logic            w_gc_load, w_gc_en, w_gc_tc;
  logic [gw-1:0]   w_gc_val;

  // start is only honoured from IDLE
  assign w_accept  = (r_state == ST_IDLE) && start;
  // a latched tmo of zero means the timeout never fires
  assign w_tmo_hit = (r_tmo != '0) && w_sc_tc;

  // shared counter: clear length in CLEAR, acknowledge timeout in ARM/STOP
  assign w_sc_load = w_accept
                   || ((r_state == ST_CLEAR) && w_sc_tc)
                   || ((r_state == ST_GATE) && w_gc_tc);
  assign w_sc_val  = (r_state == ST_IDLE) ? gw'(clr) : r_tmo;
  assign w_sc_en   = (r_state == ST_CLEAR) || (r_state == ST_ARM) || (r_state == ST_STOP);

  // gate counter: a gate length of zero runs as one cycle
  assign w_gc_load = (r_state == ST_ARM) && bac;
  assign w_gc_val  = (r_gate == '0) ? gw'(1) : r_gate;
  assign w_gc_en   = (r_state == ST_GATE);

  ctr_dncnt #(.W(gw)) u_sc (
    .clk(clk), .rst(rst), .i_load(w_sc_load), .i_val(w_sc_val), .i_en(w_sc_en), .o_tc(w_sc_tc)
  );

  ctr_dncnt #(.W(gw)) u_gc (
    .clk(clk), .rst(rst), .i_load(w_gc_load), .i_val(w_gc_val), .i_en(w_gc_en), .o_tc(w_gc_tc)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_next;
  end

  // next-state logic; bac takes precedence over a simultaneous timeout
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (start) w_state_next = ST_CLEAR;
      ST_CLEAR:   if (w_sc_tc) w_state_next = ST_ARM;
      ST_ARM:     if (bac) w_state_next = ST_GATE;
                  else if (w_tmo_hit) w_state_next = ST_ABORT;
      ST_GATE:    if (w_gc_tc) w_state_next = ST_STOP;
      ST_STOP:    if (eac) w_state_next = ST_CAPTURE;
                  else if (w_tmo_hit) w_state_next = ST_ABORT;
      ST_CAPTURE: w_state_next = ST_HOLD;
      ST_HOLD:    if (r_res_valid && res_ready) w_state_next = ST_IDLE;
      ST_ABORT:   w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // output decode from the next state so every output comes out of a flop
  always_comb begin
    w_busy_next      = (w_state_next != ST_IDLE) && (w_state_next != ST_ABORT);
    w_ctr_rst_next   = (w_state_next == ST_IDLE) || (w_state_next == ST_CLEAR)
                    || (w_state_next == ST_ABORT);
    w_brq_next       = (w_state_next == ST_ARM) || (w_state_next == ST_GATE)
                    || (w_state_next == ST_STOP) || (w_state_next == ST_CAPTURE);
    w_erq_next       = (w_state_next == ST_STOP) || (w_state_next == ST_CAPTURE);
    w_res_valid_next = (w_state_next == ST_HOLD);
    w_err_next       = r_err;
    if (w_accept) w_err_next = 1'b0;
    else if (w_state_next == ST_ABORT) w_err_next = 1'b1;
  end

  // output registers and operand latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy      <= 1'b0;
      r_ctr_rst   <= 1'b1;
      r_brq       <= 1'b0;
      r_erq       <= 1'b0;
      r_res_valid <= 1'b0;
      r_err       <= 1'b0;
      r_gate      <= '0;
      r_tmo       <= '0;
    end else begin
      r_busy      <= w_busy_next;
      r_ctr_rst   <= w_ctr_rst_next;
      r_brq       <= w_brq_next;
      r_erq       <= w_erq_next;
      r_res_valid <= w_res_valid_next;
      r_err       <= w_err_next;
      if (w_accept) begin
        r_gate <= gate;
        r_tmo  <= tmo;
      end
    end
  end

  // result capture; held untouched through HOLD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_cta <= '0;
      r_res_ctc <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_res_cta <= cta;
      r_res_ctc <= ctc;
    end
  end

  assign busy      = r_busy;
  assign ctr_rst   = r_ctr_rst;
  assign brq       = r_brq;
  assign erq       = r_erq;
  assign res_valid = r_res_valid;
  assign err       = r_err;
  assign res_cta   = r_res_cta;
  assign res_ctc   = r_res_ctc;

endmodule

// File: tb/tb_ctr_seq.sv
// Bench for ctr_seq: a small ctr model answers brq/erq, directed scenarios
// check latencies and flags, and a scoreboard monitor checks each result
// transfer against the expected counts queued when the run was started.
module tb_ctr_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] gate, tmo;
  logic        busy, ctr_rst, brq, erq;
  logic        bac, eac;
  logic [31:0] cta, ctc;
  logic [31:0] res_cta, res_ctc;
  logic        res_valid, res_ready, err;

  typedef struct {
    logic [31:0] cta;
    logic [31:0] ctc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_total = 0;
  int          n_pass  = 0;
  logic        model_bac_en, model_eac_en;
  int          brq_age, erq_age;
  logic [63:0] mon_cta, mon_ctc;
  exp_t        mon_e;
  int          n;

  always #5 clk = ~clk;

  ctr_seq dut (
    .clk(clk), .rst(rst), .start(start), .gate(gate), .tmo(tmo),
    .busy(busy), .ctr_rst(ctr_rst), .brq(brq), .erq(erq),
    .bac(bac), .eac(eac), .cta(cta), .ctc(ctc),
    .res_cta(res_cta), .res_ctc(res_ctc), .res_valid(res_valid),
    .res_ready(res_ready), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic sig(input int i);
    case (i)
      0: return brq;
      1: return erq;
      2: return bac;
      3: return eac;
      4: return res_valid;
      5: return err;
      6: return busy;
      default: return 1'b0;
    endcase
  endfunction

  // counts clock cycles until the chosen signal reads v; max+1 on timeout
  task automatic wait_sig(input int i, input logic v, input int max, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #3;
      cnt++;
    end while ((sig(i) !== v) && (cnt <= max));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #3;
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin @(posedge clk); #3; end
  endtask

  // ctr model: bac three cycles after brq rises, eac two cycles after erq rises
  initial begin
    bac = 1'b0; eac = 1'b0; brq_age = 0; erq_age = 0;
    forever begin
      @(posedge clk); #1;
      brq_age = brq ? brq_age + 1 : 0;
      erq_age = erq ? erq_age + 1 : 0;
      bac = model_bac_en && brq && (brq_age >= 4);
      eac = model_eac_en && erq && (erq_age >= 3);
    end
  end

  // scoreboard monitor: every completed result transfer pops one expectation
  always @(negedge clk) begin
    if (rst && res_valid && res_ready) begin
      if (sb_q.size() > 0) begin
        mon_e   = sb_q.pop_front();
        mon_cta = {32'h0, mon_e.cta};
        mon_ctc = {32'h0, mon_e.ctc};
      end else begin
        mon_cta = 64'h1_0000_0000;
        mon_ctc = 64'h1_0000_0000;
      end
      $display("result transfer: cta=0x%08h ctc=0x%08h", res_cta, res_ctc);
      chk("sb_cta", {32'h0, res_cta}, mon_cta);
      chk("sb_ctc", {32'h0, res_ctc}, mon_ctc);
    end
  end

  initial begin
    rst = 1'b0; start = 1'b0; gate = '0; tmo = '0;
    cta = '0; ctc = '0; res_ready = 1'b0;
    model_bac_en = 1'b1; model_eac_en = 1'b1;
    idle_cycles(3);
    chk("rst_ctr_rst", ctr_rst, 1); chk("rst_brq", brq, 0); chk("rst_erq", erq, 0);
    chk("rst_busy", busy, 0); chk("rst_valid", res_valid, 0); chk("rst_err", err, 0);
    chk("rst_res_cta", res_cta, 0); chk("rst_res_ctc", res_ctc, 0);
    rst = 1'b1;
    idle_cycles(2);

    // normal measurement, host not ready at first
    gate = 24'd10; tmo = 24'd0; cta = 32'h15; ctc = 32'h40;
    sb_q.push_back('{cta: 32'h15, ctc: 32'h40});
    pulse_start();
    chk("busy_after_start", busy, 1);
    wait_sig(0, 1'b1, 20, n);   chk("start_to_brq", n + 1, 3);
    wait_sig(2, 1'b1, 20, n);
    wait_sig(1, 1'b1, 40, n);   chk("bac_to_erq_g10", n, 11);
    wait_sig(3, 1'b1, 20, n);
    wait_sig(4, 1'b1, 20, n);   chk("eac_to_valid", n, 2);
    chk("res_cta_n", res_cta, 32'h15); chk("res_ctc_n", res_ctc, 32'h40);
    chk("hold_brq", brq, 0); chk("hold_erq", erq, 0); chk("hold_ctr_rst", ctr_rst, 0);
    idle_cycles(3);
    chk("valid_held", res_valid, 1);
    res_ready = 1'b1;
    @(posedge clk); #3;
    res_ready = 1'b0;
    chk("post_xfer_valid", res_valid, 0); chk("post_xfer_busy", busy, 0);
    chk("post_xfer_ctr_rst", ctr_rst, 1);
    idle_cycles(2);

    // backpressure: result and busy hold, start pulses ignored
    gate = 24'd3; cta = 32'h1234; ctc = 32'h5678;
    sb_q.push_back('{cta: 32'h1234, ctc: 32'h5678});
    pulse_start();
    wait_sig(4, 1'b1, 60, n);   chk("bp_valid_seen", res_valid, 1);
    cta = 32'hDEAD; ctc = 32'hBEEF;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5) || (i == 12);
      @(posedge clk); #3;
      chk("bp_valid", res_valid, 1); chk("bp_busy", busy, 1);
      chk("bp_cta", res_cta, 32'h1234); chk("bp_ctc", res_ctc, 32'h5678);
    end
    res_ready = 1'b1; start = 1'b1;
    @(posedge clk); #3;
    res_ready = 1'b0; start = 1'b0;
    chk("bp_done_valid", res_valid, 0); chk("bp_done_busy", busy, 0);
    chk("bp_done_ctr_rst", ctr_rst, 1);
    idle_cycles(3);
    chk("hs_start_ignored_busy", busy, 0); chk("hs_start_ignored_brq", brq, 0);

    // begin timeout: bac never comes
    res_ready = 1'b1; model_bac_en = 1'b0; gate = 24'd4; tmo = 24'd5;
    pulse_start();
    wait_sig(0, 1'b1, 20, n);
    wait_sig(5, 1'b1, 20, n);   chk("begin_tmo_cycles", n, 5);
    chk("btmo_brq", brq, 0); chk("btmo_busy", busy, 0);
    chk("btmo_ctr_rst", ctr_rst, 1); chk("btmo_valid", res_valid, 0);
    idle_cycles(2);
    chk("err_sticky", err, 1);

    // end timeout: bac fine, eac never comes; start clears err
    model_bac_en = 1'b1; model_eac_en = 1'b0; tmo = 24'd4;
    pulse_start();
    chk("err_cleared", err, 0);
    wait_sig(1, 1'b1, 40, n);
    wait_sig(5, 1'b1, 20, n);   chk("end_tmo_cycles", n, 4);
    chk("etmo_ctr_rst", ctr_rst, 1); chk("etmo_erq", erq, 0);
    idle_cycles(2);

    // gate of zero runs as one cycle
    model_eac_en = 1'b1; gate = 24'd0; tmo = 24'd0; cta = 32'h77; ctc = 32'h88;
    sb_q.push_back('{cta: 32'h77, ctc: 32'h88});
    pulse_start();
    wait_sig(2, 1'b1, 20, n);
    wait_sig(1, 1'b1, 20, n);   chk("bac_to_erq_g0", n, 2);
    wait_sig(6, 1'b0, 20, n);   chk("g0_busy_drop", busy, 0);
    idle_cycles(2);

    // asynchronous reset in the middle of the gate
    gate = 24'd10; cta = 32'h99; ctc = 32'h99;
    pulse_start();
    wait_sig(2, 1'b1, 20, n);
    idle_cycles(3);
    rst = 1'b0;
    #1;
    chk("arst_ctr_rst", ctr_rst, 1); chk("arst_brq", brq, 0); chk("arst_erq", erq, 0);
    chk("arst_busy", busy, 0); chk("arst_valid", res_valid, 0); chk("arst_err", err, 0);
    idle_cycles(3);
    rst = 1'b1;
    idle_cycles(2);
    gate = 24'd2; cta = 32'hAA; ctc = 32'hBB;
    sb_q.push_back('{cta: 32'hAA, ctc: 32'hBB});
    pulse_start();
    wait_sig(6, 1'b0, 60, n);   chk("after_rst_done", busy, 0);
    idle_cycles(3);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
